// File: rtl/out_intf_result_collector.sv
// Result collector: buffers adder results {cout,sum} in a FWFT FIFO and
// reports a saturating per-frame total every FRAME_LEN accepted results.
// Optional macro OUT_INTF_PARITY_EN adds res_par (stored per entry).
module out_intf_result_collector #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ACC_W     = 12,
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   cout,
  input  logic [3:0]             sum,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4:0]             res_data,
`ifdef OUT_INTF_PARITY_EN
  output logic                   res_par,
`endif
  output logic                   frm_valid,
  input  logic                   frm_ready,
  output logic [ACC_W-1:0]       frm_total,
  output logic                   frm_ovf,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(FRAME_LEN + 1);
  localparam int unsigned SW = ACC_W + 1;
`ifdef OUT_INTF_PARITY_EN
  localparam int unsigned DW = 6;
`else
  localparam int unsigned DW = 5;
`endif

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_REPORT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [DW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [LW-1:0]    w_level_next;
  logic [DW-1:0]    r_head;
  logic [DW-1:0]    w_head_next;
  logic [DW-1:0]    w_entry;
  logic             r_in_ready;
  logic             r_res_valid;
  logic             r_frm_valid;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_sat;
  logic [ACC_W-1:0] r_frm_total;
  logic             r_ovf;
  logic             r_frm_ovf;
  logic             w_acc_ovf;
  logic [SW-1:0]    w_acc_sum;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;
  logic             w_frame_done;

`ifdef OUT_INTF_PARITY_EN
  assign w_entry = {^{cout, sum}, cout, sum};
`else
  assign w_entry = {cout, sum};
`endif

  // Handshakes, saturating accumulate, occupancy and next FIFO head
  always_comb begin
    w_push       = in_valid & r_in_ready;
    w_pop        = r_res_valid & res_ready;
    w_acc_sum    = SW'(r_acc) + SW'({cout, sum});
    w_acc_ovf    = w_acc_sum[ACC_W];
    w_acc_sat    = w_acc_ovf ? '1 : w_acc_sum[ACC_W-1:0];
    w_frame_done = w_push & (r_cnt == CW'(FRAME_LEN - 1));
    w_level_next = r_level + LW'(w_push) - LW'(w_pop);
    w_head_next  = r_head;
    if (w_pop) begin
      // Head advances to the next stored entry, or to the word being pushed
      if (r_level > LW'(1)) begin
        w_head_next = r_mem[r_rd_ptr + AW'(1)];
      end else if (w_push) begin
        w_head_next = w_entry;
      end
    end else if ((r_level == '0) && w_push) begin
      w_head_next = w_entry;
    end
    if (clear) begin
      w_level_next = '0;
      w_head_next  = r_head;
    end
  end

  // FSM next state: leave ACCUM on the frame-closing push, return on handshake
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCUM:  if (w_frame_done) w_state_next = ST_REPORT;
      ST_REPORT: if (r_frm_valid && frm_ready) w_state_next = ST_ACCUM;
      default:   w_state_next = ST_ACCUM;
    endcase
    if (clear) begin
      w_state_next = ST_ACCUM;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FIFO storage, no reset needed: only read when the level says valid
  always_ff @(posedge clock) begin
    if (w_push && !clear) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Pointers, registered flags, head, accumulator and frame summary
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_head      <= '0;
      r_in_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_frm_valid <= 1'b0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_frm_total <= '0;
      r_frm_ovf   <= 1'b0;
    end else begin
      r_level     <= w_level_next;
      r_head      <= w_head_next;
      r_res_valid <= (w_level_next != '0);
      r_in_ready  <= (w_level_next < LW'(DEPTH)) && (w_state_next == ST_ACCUM);
      r_frm_valid <= (w_state_next == ST_REPORT);
      if (clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_acc    <= '0;
        r_ovf    <= 1'b0;
        r_cnt    <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_frame_done) begin
          r_frm_total <= w_acc_sat;
          r_frm_ovf   <= r_ovf | w_acc_ovf;
          r_acc       <= '0;
          r_ovf       <= 1'b0;
          r_cnt       <= '0;
        end else if (w_push) begin
          r_acc <= w_acc_sat;
          r_ovf <= r_ovf | w_acc_ovf;
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign res_valid  = r_res_valid;
  assign res_data   = r_head[4:0];
`ifdef OUT_INTF_PARITY_EN
  assign res_par    = r_head[5];
`endif
  assign frm_valid  = r_frm_valid;
  assign frm_total  = r_frm_total;
  assign frm_ovf    = r_frm_ovf;
  assign fifo_level = r_level;

endmodule

// File: tb/tb_out_intf_result_collector.sv
// Bench for out_intf_result_collector: two instances (ACC_W=12 and ACC_W=8)
// share stimulus; a queue-based reference model predicts both.
module tb_out_intf_result_collector;

  localparam int DEPTH     = 8;
  localparam int FRAME_LEN = 16;

  logic       clock = 1'b0;
  logic       reset, clear, in_valid, cout, res_ready, frm_ready;
  logic [3:0] sum;

  logic        in_ready_a, res_valid_a, frm_valid_a, frm_ovf_a;
  logic [4:0]  res_data_a;
  logic [11:0] frm_total_a;
  logic [3:0]  fifo_level_a;
  logic        in_ready_b, res_valid_b, frm_valid_b, frm_ovf_b;
  logic [4:0]  res_data_b;
  logic [7:0]  frm_total_b;
  logic [3:0]  fifo_level_b;
`ifdef OUT_INTF_PARITY_EN
  logic        res_par_a, res_par_b;
`endif

  always #5 clock = ~clock;

  out_intf_result_collector dut_a (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_a), .cout(cout), .sum(sum),
    .res_valid(res_valid_a), .res_ready(res_ready), .res_data(res_data_a),
`ifdef OUT_INTF_PARITY_EN
    .res_par(res_par_a),
`endif
    .frm_valid(frm_valid_a), .frm_ready(frm_ready), .frm_total(frm_total_a),
    .frm_ovf(frm_ovf_a), .fifo_level(fifo_level_a)
  );

  out_intf_result_collector #(.ACC_W(8)) dut_b (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_b), .cout(cout), .sum(sum),
    .res_valid(res_valid_b), .res_ready(res_ready), .res_data(res_data_b),
`ifdef OUT_INTF_PARITY_EN
    .res_par(res_par_b),
`endif
    .frm_valid(frm_valid_b), .frm_ready(frm_ready), .frm_total(frm_total_b),
    .frm_ovf(frm_ovf_b), .fifo_level(fifo_level_b)
  );

  // Reference model state
  int q[$];
  int last_v;
  int tot[2];
  bit movf[2];
  int ftot[2];
  bit fovf[2];
  int maxv[2];
  int cnt;
  bit rep;
  bit started;
  int checks;
  int errors;

  typedef struct {
    logic       iv;
    logic [4:0] d;
    logic       rr;
    logic       clr;
    logic       e_rv;
    logic [4:0] e_rd;
    int         e_lvl;
    logic       e_ir;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_v = 0; cnt = 0; rep = 1'b0; started = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tot[k] = 0; movf[k] = 1'b0; ftot[k] = 0; fovf[k] = 1'b0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    bit acc, push, pop, nov;
    int v, s;
    acc  = started && (q.size() < DEPTH) && !rep;
    push = in_valid && acc;
    pop  = (q.size() != 0) && res_ready;
    v    = int'({cout, sum});
    started = 1'b1;
    if (clear) begin
      q.delete(); cnt = 0; rep = 1'b0;
      for (int k = 0; k < 2; k++) begin tot[k] = 0; movf[k] = 1'b0; end
    end else begin
      if (rep && frm_ready) rep = 1'b0;
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(v);
        cnt++;
        for (int k = 0; k < 2; k++) begin
          s = tot[k] + v; nov = 1'b0;
          if (s > maxv[k]) begin s = maxv[k]; nov = 1'b1; end
          if (cnt == FRAME_LEN) begin
            ftot[k] = s; fovf[k] = movf[k] | nov; tot[k] = 0; movf[k] = 1'b0;
          end else begin
            tot[k] = s; movf[k] = movf[k] | nov;
          end
        end
        if (cnt == FRAME_LEN) begin cnt = 0; rep = 1'b1; end
      end
    end
    if (q.size() != 0) last_v = q[0];
  endtask

  task automatic check_model();
    int exp_ir;
    logic [4:0] erd;
    exp_ir = (started && (q.size() < DEPTH) && !rep) ? 1 : 0;
    erd = 5'(last_v);
    chk("a_in_ready", int'(in_ready_a), exp_ir);
    chk("b_in_ready", int'(in_ready_b), exp_ir);
    chk("a_res_valid", int'(res_valid_a), (q.size() != 0) ? 1 : 0);
    chk("b_res_valid", int'(res_valid_b), (q.size() != 0) ? 1 : 0);
    chk("a_res_data", int'(res_data_a), last_v);
    chk("b_res_data", int'(res_data_b), last_v);
    chk("a_level", int'(fifo_level_a), q.size());
    chk("b_level", int'(fifo_level_b), q.size());
    chk("a_frm_valid", int'(frm_valid_a), int'(rep));
    chk("b_frm_valid", int'(frm_valid_b), int'(rep));
    chk("a_frm_total", int'(frm_total_a), ftot[0]);
    chk("b_frm_total", int'(frm_total_b), ftot[1]);
    chk("a_frm_ovf", int'(frm_ovf_a), int'(fovf[0]));
    chk("b_frm_ovf", int'(frm_ovf_b), int'(fovf[1]));
`ifdef OUT_INTF_PARITY_EN
    chk("a_res_par", int'(res_par_a), int'(^erd));
    chk("b_res_par", int'(res_par_b), int'(^erd));
`else
    if (erd > 5'd31) chk("res_data_range", int'(erd), 31);
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check_model();
  endtask

  task automatic idle();
    in_valid = 1'b0; clear = 1'b0; res_ready = 1'b0; frm_ready = 1'b0;
    {cout, sum} = 5'h00;
  endtask

  // Push n copies of v, bounded by a cycle budget
  task automatic push_n(input int n, input logic [4:0] v, input logic rr);
    int got = 0;
    int budget = 200;
    bit acc;
    while (got < n && budget > 0) begin
      in_valid = 1'b1; {cout, sum} = v; res_ready = rr;
      acc = started && (q.size() < DEPTH) && !rep;
      step();
      if (acc) got++;
      budget--;
    end
    in_valid = 1'b0;
    if (got != n) chk("push_budget", got, n);
  endtask

  task automatic do_clear();
    idle(); clear = 1'b1; step(); clear = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    maxv[0] = 4095; maxv[1] = 255;
    tbl[0] = '{1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'h00, 0, 1'b1};
    tbl[1] = '{1'b1, 5'h05, 1'b0, 1'b0, 1'b1, 5'h05, 1, 1'b1};
    tbl[2] = '{1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 5'h05, 0, 1'b1};
    tbl[3] = '{1'b1, 5'h1A, 1'b1, 1'b0, 1'b1, 5'h1A, 1, 1'b1};
    tbl[4] = '{1'b1, 5'h03, 1'b1, 1'b0, 1'b1, 5'h03, 1, 1'b1};
    tbl[5] = '{1'b1, 5'h11, 1'b0, 1'b0, 1'b1, 5'h03, 2, 1'b1};
    tbl[6] = '{1'b1, 5'h1F, 1'b1, 1'b1, 1'b0, 5'h03, 0, 1'b1};
    tbl[7] = '{1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'h03, 0, 1'b1};

    idle();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", int'(in_ready_a), 0);
    chk("rst_res_valid", int'(res_valid_a), 0);
    chk("rst_level", int'(fifo_level_a), 0);
    chk("rst_frm_valid", int'(frm_valid_a), 0);
    reset = 1'b1;

    // Basic push/pop, simultaneous push/pop and clear behaviour
    for (int i = 0; i < 8; i++) begin
      in_valid = tbl[i].iv; {cout, sum} = tbl[i].d;
      res_ready = tbl[i].rr; clear = tbl[i].clr; frm_ready = 1'b0;
      step();
      chk($sformatf("tbl%0d_res_valid", i), int'(res_valid_a), int'(tbl[i].e_rv));
      chk($sformatf("tbl%0d_res_data", i), int'(res_data_a), int'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_level", i), int'(fifo_level_a), tbl[i].e_lvl);
      chk($sformatf("tbl%0d_in_ready", i), int'(in_ready_a), int'(tbl[i].e_ir));
    end
    idle();

    // Full FIFO: a same-cycle pop does not admit the 9th push
    do_clear();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; {cout, sum} = 5'(i + 1); res_ready = 1'b0;
      step();
    end
    chk("full_level", int'(fifo_level_a), 8);
    chk("full_in_ready", int'(in_ready_a), 0);
    in_valid = 1'b1; {cout, sum} = 5'h09; res_ready = 1'b1;
    step();
    chk("full_pop_level", int'(fifo_level_a), 7);
    chk("full_pop_head", int'(res_data_a), 2);
    res_ready = 1'b0;
    step();
    chk("ninth_level", int'(fifo_level_a), 8);
    do_clear();

    // Frame of 0x1F: normal total on 12 bits, saturation on 8 bits
    push_n(FRAME_LEN, 5'h1F, 1'b1);
    chk("f1_frm_valid", int'(frm_valid_a), 1);
    chk("f1_total_a", int'(frm_total_a), 496);
    chk("f1_ovf_a", int'(frm_ovf_a), 0);
    chk("f1_total_b", int'(frm_total_b), 255);
    chk("f1_ovf_b", int'(frm_ovf_b), 1);
    chk("f1_in_ready", int'(in_ready_a), 0);
    in_valid = 1'b1; res_ready = 1'b1;
    repeat (2) step();
    chk("f1_hold_total", int'(frm_total_a), 496);
    in_valid = 1'b0; frm_ready = 1'b1;
    step();
    frm_ready = 1'b0;
    chk("f1_hs_frm_valid", int'(frm_valid_a), 0);
    chk("f1_hs_in_ready", int'(in_ready_a), 1);
    push_n(FRAME_LEN, 5'h01, 1'b1);
    chk("f2_total_b", int'(frm_total_b), 16);
    chk("f2_ovf_b", int'(frm_ovf_b), 0);
    frm_ready = 1'b1; step(); frm_ready = 1'b0;

    // Clear mid-frame discards FIFO and partial total
    push_n(5, 5'h0A, 1'b0);
    in_valid = 1'b1; res_ready = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    chk("clr_level", int'(fifo_level_a), 0);
    chk("clr_res_valid", int'(res_valid_a), 0);
    push_n(FRAME_LEN, 5'h02, 1'b1);
    chk("clr_frm_total_a", int'(frm_total_a), 32);
    chk("clr_frm_total_b", int'(frm_total_b), 32);
    frm_ready = 1'b1; step(); frm_ready = 1'b0;
    do_clear();

`ifdef OUT_INTF_PARITY_EN
    // Parity follows the head entry
    in_valid = 1'b1; {cout, sum} = 5'h07; res_ready = 1'b0; step();
    {cout, sum} = 5'h03; step();
    in_valid = 1'b0;
    chk("par_first", int'(res_par_a), 1);
    res_ready = 1'b1; step(); res_ready = 1'b0;
    chk("par_second", int'(res_par_a), 0);
    do_clear();
`endif

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      {cout, sum} = 5'($urandom_range(0, 31));
      res_ready = (c % 600 < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      frm_ready = ($urandom_range(0, 3) == 0);
      clear     = ($urandom_range(0, 249) == 0);
      step();
    end
    idle();

    // Asynchronous reset in the middle of traffic
    push_n(3, 5'h15, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_res_valid", int'(res_valid_a), 0);
    chk("arst_level", int'(fifo_level_a), 0);
    chk("arst_res_data", int'(res_data_a), 0);
    chk("arst_in_ready", int'(in_ready_a), 0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    step();
    chk("arst_in_ready_after", int'(in_ready_a), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
